// File: rtl/tcdm_36_to_32_tag_splitter.sv
// Purpose: responder side of the 36-bit tagged TCDM bus; strips one tag bit per byte, keeps tags locally, re-merges them into read responses.
// Latency: zero added cycles on both request and response paths (combinational pass-through; tags come from flops).
// Backpressure: gnt/req blocked while MAX_OUTSTANDING tag entries are pending; responses are never stalled.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   s36_*                 36-bit tagged initiator side (req/add/wen/be/wdata in, gnt/r_valid/r_opc/r_rdata out)
//   m32_*                 32-bit legacy bank side (req/add/wen/be/wdata out, gnt/r_valid/r_opc/r_rdata in)
//   outstanding_o         accepted requests still waiting for a bank response
//   underflow_err_o       sticky flag: a bank response arrived with nothing outstanding
module tcdm_36_to_32_tag_splitter #(
    parameter int   TAG_WORDS       = 1024,
    parameter int   MAX_OUTSTANDING = 2,
    parameter logic TAG_RESET_VALUE = 1'b0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,

    input  logic                               s36_req_i,
    input  logic [31:0]                        s36_add_i,
    input  logic                               s36_wen_i,
    input  logic [3:0]                         s36_be_i,
    input  logic [35:0]                        s36_wdata_i,
    output logic                               s36_gnt_o,
    output logic                               s36_r_valid_o,
    output logic                               s36_r_opc_o,
    output logic [35:0]                        s36_r_rdata_o,

    output logic                               m32_req_o,
    output logic [31:0]                        m32_add_o,
    output logic                               m32_wen_o,
    output logic [3:0]                         m32_be_o,
    output logic [31:0]                        m32_wdata_o,
    input  logic                               m32_gnt_i,
    input  logic                               m32_r_valid_i,
    input  logic                               m32_r_opc_i,
    input  logic [31:0]                        m32_r_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               underflow_err_o
);

    localparam int IDX_W = $clog2(TAG_WORDS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]        tag_q  [TAG_WORDS];
    logic [3:0]        tag_d  [TAG_WORDS];
    logic [3:0]        fifo_q [MAX_OUTSTANDING];
    logic [3:0]        fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              uf_err_q, uf_err_d;

    // ------------------------------------------------------------------
    // Request-side decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  idx;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [3:0]        head_tags;

    // Upper address bits and the byte offset do not select a tag word:
    // the store aliases every 4*TAG_WORDS bytes.
    logic              unused_add;
    assign unused_add = ^{s36_add_i[31:IDX_W+2], s36_add_i[1:0]};

    assign idx   = s36_add_i[IDX_W+1:2];
    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // Full is taken from the registered count only, so a response popping
    // in the same cycle never feeds combinationally into the grant.
    assign m32_req_o = s36_req_i & ~full & ~rst_i;
    assign s36_gnt_o = m32_gnt_i & ~full & ~rst_i;

    assign m32_add_o = s36_add_i;
    assign m32_wen_o = s36_wen_i;
    assign m32_be_o  = s36_be_i;

    assign push = s36_req_i & s36_gnt_o;
    assign pop  = m32_r_valid_i & ~empty;

    always_comb begin
        m32_wdata_o = '0;
        for (int i = 0; i < 4; i++) begin
            m32_wdata_o[8*i +: 8] = s36_wdata_i[9*i +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Response-side merge
    // ------------------------------------------------------------------
    // A response with nothing outstanding has no tag to pair with; it is
    // returned with reset-value tags and flagged as underflow.
    assign head_tags = empty ? {4{TAG_RESET_VALUE}} : fifo_q[rd_ptr_q];

    assign s36_r_valid_o = m32_r_valid_i;
    assign s36_r_opc_o   = m32_r_opc_i;

    always_comb begin
        s36_r_rdata_o = '0;
        for (int i = 0; i < 4; i++) begin
            s36_r_rdata_o[9*i +: 8] = m32_r_rdata_i[8*i +: 8];
            s36_r_rdata_o[9*i + 8]  = head_tags[i];
        end
    end

    assign outstanding_o   = count_q;
    assign underflow_err_o = uf_err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Tag store: only enabled bytes of an accepted write take new tags.
    always_comb begin
        tag_d = tag_q;
        if (push && !s36_wen_i) begin
            for (int i = 0; i < 4; i++) begin
                if (s36_be_i[i]) begin
                    tag_d[idx][i] = s36_wdata_i[9*i + 8];
                end
            end
        end
    end

    // Outstanding FIFO: every accept occupies a slot (writes included) so
    // slot order matches the bank's one-response-per-grant order. The value
    // pushed is the tag before this cycle's write update.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        uf_err_d = uf_err_q;

        if (push) begin
            fifo_d[wr_ptr_q] = tag_q[idx];
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (m32_r_valid_i && empty) begin
            uf_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < TAG_WORDS; w++) begin
                tag_q[w] <= {4{TAG_RESET_VALUE}};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            uf_err_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            uf_err_q <= uf_err_d;
        end
    end

    // FIFO payload needs no reset: slots are only read after being written.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fifo_q <= fifo_d;
        end
    end

endmodule

// File: tb/tb_tcdm_36_to_32_tag_splitter.sv
`timescale 1ns/1ps
module tb_tcdm_36_to_32_tag_splitter;

    localparam int TAG_WORDS = 1024;
    localparam int MAX_OUT   = 2;
    localparam int OW        = $clog2(MAX_OUT) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          s36_req_i = 1'b0;
    logic [31:0]   s36_add_i = '0;
    logic          s36_wen_i = 1'b1;
    logic [3:0]    s36_be_i = '0;
    logic [35:0]   s36_wdata_i = '0;
    logic          s36_gnt_o;
    logic          s36_r_valid_o;
    logic          s36_r_opc_o;
    logic [35:0]   s36_r_rdata_o;
    logic          m32_req_o;
    logic [31:0]   m32_add_o;
    logic          m32_wen_o;
    logic [3:0]    m32_be_o;
    logic [31:0]   m32_wdata_o;
    logic          m32_gnt_i = 1'b0;
    logic          m32_r_valid_i = 1'b0;
    logic          m32_r_opc_i = 1'b0;
    logic [31:0]   m32_r_rdata_i = '0;
    logic [OW-1:0] outstanding_o;
    logic          underflow_err_o;

    always #5 clk_i = ~clk_i;

    tcdm_36_to_32_tag_splitter #(
        .TAG_WORDS(TAG_WORDS), .MAX_OUTSTANDING(MAX_OUT), .TAG_RESET_VALUE(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s36_req_i(s36_req_i), .s36_add_i(s36_add_i), .s36_wen_i(s36_wen_i),
        .s36_be_i(s36_be_i), .s36_wdata_i(s36_wdata_i), .s36_gnt_o(s36_gnt_o),
        .s36_r_valid_o(s36_r_valid_o), .s36_r_opc_o(s36_r_opc_o), .s36_r_rdata_o(s36_r_rdata_o),
        .m32_req_o(m32_req_o), .m32_add_o(m32_add_o), .m32_wen_o(m32_wen_o),
        .m32_be_o(m32_be_o), .m32_wdata_o(m32_wdata_o), .m32_gnt_i(m32_gnt_i),
        .m32_r_valid_i(m32_r_valid_i), .m32_r_opc_i(m32_r_opc_i), .m32_r_rdata_i(m32_r_rdata_i),
        .outstanding_o(outstanding_o), .underflow_err_o(underflow_err_o)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: tag per word index, list of pending responses in order.
    typedef struct { logic [3:0] tags; bit is_rd; } pend_t;
    logic [3:0] m_tag [TAG_WORDS];
    pend_t      m_q[$];
    bit         m_uf = 1'b0;

    // Bank emulation: in-order responses, each due a number of cycles after its grant.
    typedef struct { logic [31:0] data; int due; } bresp_t;
    bresp_t      b_q[$];
    logic [31:0] b_mem [logic [29:0]];
    bit          bank_gnt_en = 1'b1;
    bit          bank_hold   = 1'b0;
    bit          force_rvld  = 1'b0;
    int          lat_min = 1, lat_max = 1;
    logic [35:0] rlog[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] pack(input logic [31:0] d, input logic [3:0] t);
        logic [35:0] r;
        for (int i = 0; i < 4; i++) begin
            r[9*i +: 8] = d[8*i +: 8];
            r[9*i + 8]  = t[i];
        end
        return r;
    endfunction

    function automatic logic [3:0] tags_of(input logic [35:0] r);
        return {r[35], r[26], r[17], r[8]};
    endfunction

    function automatic logic [31:0] strip(input logic [35:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[9*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < TAG_WORDS; w++) m_tag[w] = 4'b0000;
        m_q.delete();
        b_q.delete();
        m_uf = 1'b0;
    endtask

    // One bus cycle: drive on negedge, check combinational outputs, advance model.
    task automatic cycle(input bit req, input bit wen, input logic [31:0] add,
                         input logic [3:0] be, input logic [35:0] wdata);
        bit          full, e_gnt, e_req, acc, rv, pop_bank, opc;
        logic [31:0] rd, old;
        logic [35:0] e_rd, mask;
        logic [3:0]  htag;
        bit          h_rd;
        int          idx;
        @(negedge clk_i);
        full     = (m_q.size() == MAX_OUT);
        pop_bank = !force_rvld && !bank_hold && b_q.size() > 0 && b_q[0].due <= cyc;
        rv       = force_rvld || pop_bank;
        rd       = pop_bank ? b_q[0].data : $urandom;
        opc      = 1'($urandom);
        s36_req_i = req; s36_add_i = add; s36_wen_i = wen; s36_be_i = be; s36_wdata_i = wdata;
        m32_gnt_i = bank_gnt_en; m32_r_valid_i = rv; m32_r_opc_i = opc; m32_r_rdata_i = rd;
        #1;
        e_gnt = bank_gnt_en && !full;
        e_req = req && !full;
        acc   = req && e_gnt;
        chk("s36_gnt", 64'(s36_gnt_o), 64'(e_gnt));
        chk("m32_req", 64'(m32_req_o), 64'(e_req));
        chk("passthru", {m32_add_o, m32_wen_o, m32_be_o}, {add, wen, be});
        chk("m32_wdata", 64'(m32_wdata_o), 64'(strip(wdata)));
        chk("r_valid", 64'(s36_r_valid_o), 64'(rv));
        chk("r_opc", 64'(s36_r_opc_o), 64'(opc));
        chk("outstanding", 64'(outstanding_o), 64'(m_q.size()));
        chk("underflow_err", 64'(underflow_err_o), 64'(m_uf));
        if (rv) begin
            htag = (m_q.size() > 0) ? m_q[0].tags : 4'b0000;
            h_rd = (m_q.size() == 0) || m_q[0].is_rd;
            e_rd = pack(rd, htag);
            mask = pack(32'hFFFF_FFFF, h_rd ? 4'hF : 4'h0);
            chk("r_rdata", 64'(s36_r_rdata_o & mask), 64'(e_rd & mask));
            if (h_rd) rlog.push_back(s36_r_rdata_o);
            if (m_q.size() > 0) void'(m_q.pop_front());
            else                m_uf = 1'b1;
            if (pop_bank) void'(b_q.pop_front());
        end
        if (acc) begin
            idx = int'(add[11:2]);
            m_q.push_back('{m_tag[idx], wen});
            old = b_mem.exists(add[31:2]) ? b_mem[add[31:2]] : 32'h0;
            b_q.push_back('{wen ? old : $urandom, cyc + $urandom_range(lat_min, lat_max)});
            if (!wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        m_tag[idx][i]  = wdata[9*i + 8];
                        old[8*i +: 8]  = wdata[9*i +: 8];
                    end
                end
                b_mem[add[31:2]] = old;
            end
        end
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 32'h0, 4'h0, 36'h0);
    endtask

    task automatic wr(input logic [31:0] add, input logic [3:0] be, input logic [31:0] d, input logic [3:0] t);
        cycle(1'b1, 1'b0, add, be, pack(d, t));
    endtask

    task automatic rd_req(input logic [31:0] add);
        cycle(1'b1, 1'b1, add, 4'hF, 36'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_q.size() > 0) && (n < 60)) begin
            idle();
            n++;
        end
        if (m_q.size() > 0) chk("drain_timeout", 64'(m_q.size()), 64'd0);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; s36_req_i = 1'b1; m32_gnt_i = 1'b1; m32_r_valid_i = 1'b0;
        #1;
        chk("rst_gnt", 64'(s36_gnt_o), 64'd0);
        chk("rst_req", 64'(m32_req_o), 64'd0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("post_rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("post_rst_underflow", 64'(underflow_err_o), 64'd0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Write with tags 1010 then read it back with 1-cycle bank latency.
        rlog.delete();
        wr(32'h10, 4'hF, 32'hDEAD_BEEF, 4'b1010);
        rd_req(32'h10);
        drain();
        chk("t1_count", 64'(rlog.size()), 64'd1);
        if (rlog.size() > 0) chk("t1_rdata", 64'(rlog[0]), 64'(pack(32'hDEAD_BEEF, 4'b1010)));

        // Partial-byte tag update.
        rlog.delete();
        wr(32'h20, 4'hF, 32'h1234_5678, 4'b1111);
        wr(32'h20, 4'b0101, 32'h0, 4'b0000);
        rd_req(32'h20);
        drain();
        chk("t2_count", 64'(rlog.size()), 64'd1);
        if (rlog.size() > 0) chk("t2_tags", 64'(tags_of(rlog[0])), 64'(4'b1010));

        // Full FIFO blocks grant; releasing one response reopens it a cycle later.
        bank_hold = 1'b1;
        rd_req(32'h10);
        rd_req(32'h10);
        rd_req(32'h10);
        bank_hold = 1'b0;
        rd_req(32'h10);
        bank_hold = 1'b1;
        rd_req(32'h10);
        rd_req(32'h10);
        chk("t3_out_full", 64'(outstanding_o), 64'd2);
        chk("t3_gnt_blocked", 64'(s36_gnt_o), 64'd0);
        bank_hold = 1'b0;
        drain();

        // Back-to-back reads, staggered responses, in-order tags.
        wr(32'h0, 4'hF, 32'hA5A5_0001, 4'b0001);
        wr(32'h4, 4'hF, 32'h5A5A_1000, 4'b1000);
        drain();
        rlog.delete();
        lat_min = 1; lat_max = 4;
        rd_req(32'h0);
        rd_req(32'h4);
        drain();
        lat_min = 1; lat_max = 1;
        chk("t4_count", 64'(rlog.size()), 64'd2);
        if (rlog.size() > 1) begin
            chk("t4_first", 64'(tags_of(rlog[0])), 64'(4'b0001));
            chk("t4_second", 64'(tags_of(rlog[1])), 64'(4'b1000));
        end

        // Response with nothing outstanding.
        force_rvld = 1'b1;
        idle();
        force_rvld = 1'b0;
        idle();
        idle();
        chk("t5_underflow_sticky", 64'(underflow_err_o), 64'd1);

        // Reset with two reads outstanding and nonzero tags.
        bank_hold = 1'b1;
        rd_req(32'h10);
        rd_req(32'h4);
        bank_hold = 1'b0;
        do_reset();
        chk("t6_outstanding", 64'(outstanding_o), 64'd0);
        rlog.delete();
        rd_req(32'h10);
        rd_req(32'h4);
        drain();
        chk("t6_count", 64'(rlog.size()), 64'd2);
        if (rlog.size() > 1) begin
            chk("t6_tags_a", 64'(tags_of(rlog[0])), 64'd0);
            chk("t6_tags_b", 64'(tags_of(rlog[1])), 64'd0);
        end

        // Randomized traffic with aliasing addresses and random bank behaviour.
        lat_min = 1; lat_max = 4;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            bank_gnt_en = ($urandom_range(0, 3) != 0);
            a = {20'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 2'($urandom)};
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), a, 4'($urandom), 36'({$urandom, $urandom}));
        end
        bank_gnt_en = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tcdm_36_to_32_tag_splitter.md
Name: tcdm_36_to_32_tag_splitter

Overview:
- Responder side of the 36-bit tagged TCDM bus used by the DIFT extension.
- Accepts XBAR_TCDM_BUS_36 transactions, where each byte carries one tag bit (bits 8/17/26/35). Forwards the 32 data bits to a legacy 32-bit TCDM bank.
- Holds the tag bits in a local flop-based tag store.
- Re-merges the tags into read responses through an outstanding-request FIFO, so that tags stay aligned with downstream responses that may stall or arrive late.

Parameters:
- TAG_WORDS, 1024, number of 32-bit words covered by the tag store (power of 2).
- MAX_OUTSTANDING, 2, depth of the outstanding-tag FIFO (power of 2, ≥1).
- TAG_RESET_VALUE, 1'b0, value of every tag bit after reset and of tags returned on underflow.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s36_req_i  in  1  request from 36-bit initiator
- s36_add_i  in  32  byte address
- s36_wen_i  in  1  0 = write, 1 = read
- s36_be_i  in  4  byte enables
- s36_wdata_i  in  36  write data, tag in bit 9*i+8 for byte i
- s36_gnt_o  out  1  grant
- s36_r_valid_o  out  1  response valid
- s36_r_opc_o  out  1  response error flag
- s36_r_rdata_o  out  36  read data with tags merged
- m32_req_o  out  1  request to 32-bit bank
- m32_add_o  out  32  byte address
- m32_wen_o  out  1  write enable (active low)
- m32_be_o  out  4  byte enables
- m32_wdata_o  out  32  data bytes with tags stripped
- m32_gnt_i  in  1  bank grant
- m32_r_valid_i  in  1  bank response valid
- m32_r_opc_i  in  1  bank response error
- m32_r_rdata_i  in  32  bank read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  number of accepted requests not yet responded
- underflow_err_o  out  1  sticky: response arrived with empty FIFO

Behaviour:
- Index: idx = s36_add_i[$clog2(TAG_WORDS)+1:2]. Upper address bits are ignored, so the tag store aliases with period 4*TAG_WORDS bytes.
- Request path (combinational):
  - m32_req_o = s36_req_i & ~full.
  - s36_gnt_o = m32_gnt_i & ~full.
  - add, wen and be pass straight through.
  - m32_wdata_o byte i = s36_wdata_i[9i+7:9i].
- full = (count == MAX_OUTSTANDING). Grant is blocked while full even if a response pops in the same cycle, so there is no combinational path from r_valid to gnt.
- Accept = s36_req_i & s36_gnt_o. On accept:
  - Push tag[idx] (the value before any update this cycle) into the FIFO.
  - For a write, additionally at the clock edge: tag[idx][i] <= s36_wdata_i[9i+8] for each i with be[i]=1. Bytes with be[i]=0 keep their tag.
  - Write pushes still occupy a FIFO slot; the pushed tag is don't-care.
- Response path (combinational from FIFO head):
  - s36_r_valid_o = m32_r_valid_i.
  - s36_r_opc_o = m32_r_opc_i.
  - s36_r_rdata_o[9i+7:9i] = m32_r_rdata_i byte i.
  - s36_r_rdata_o[9i+8] = head[i].
  - When m32_r_valid_i=1, pop the FIFO.
- Responses are in order; the bank returns exactly one r_valid per grant, at least 1 cycle later.
- Simultaneous push and pop: count unchanged, and the head/tail pointers wrap modulo MAX_OUTSTANDING.
- Read after write to the same word in consecutive accepts returns the newly written tags.
- Underflow: if m32_r_valid_i=1 while count==0:
  - Tags returned = {4{TAG_RESET_VALUE}}.
  - No pop; count stays 0.
  - underflow_err_o set; it clears only on reset.
- Reset (rst_i=1 on a clock edge, including mid-transaction):
  - All tags <= TAG_RESET_VALUE.
  - FIFO pointers and count <= 0.
  - underflow_err_o <= 0.
  - While rst_i=1, s36_gnt_o and m32_req_o are forced to 0.
  - The bank must be reset in the same cycle; stale responses after reset count as underflow.
- Output values after reset: gnt 0 (while in reset), outstanding_o 0, underflow_err_o 0. Response outputs follow the bank inputs.
- Latency: zero added cycles on both request and response paths.

Test Plan:
- Write add=0x10, be=4'b1111, wdata with tags 4'b1010 and data 0xDEADBEEF, then read 0x10 with 1-cycle bank latency -> m32_wdata=0xDEADBEEF, read returns data 0xDEADBEEF, tag bits {35,26,17,8}={1,0,1,0}.
- Write tags 4'b1111 be=1111, then write tags 4'b0000 be=4'b0101 to the same word, then read -> tags byte3..0 = 1,0,1,0.
- MAX_OUTSTANDING=2, bank grants but withholds r_valid -> after 2 accepts s36_gnt_o=0 and m32_req_o=0 with req held. Release one r_valid -> gnt returns the next cycle; outstanding_o goes 2→1→2.
- Back-to-back reads of words 0x0 (tags 0001) and 0x4 (tags 1000) with staggered bank responses -> responses carry 0001 then 1000, in order.
- r_valid pulse with no outstanding request -> returned tags = TAG_RESET_VALUE, underflow_err_o=1 and stays 1 until rst_i.
- Assert rst_i with 2 outstanding requests and nonzero tags -> next cycle outstanding_o=0, and a read of any previously tagged word returns tags 0000.
